approx_error_monitor: RTL and testbench

//  Downstream consumer of the 8-bit approximate adder. Takes paired approximate and exact 9-bit results ({cout,sum}).

---
 rtl/approx_error_monitor_pkg.sv | 25 ++
 rtl/approx_error_monitor_if.sv | 42 ++++
 rtl/approx_error_monitor_err_dist_calc.sv | 40 ++++
 rtl/approx_error_monitor.sv | 133 +++++++++++++
 tb/tb_approx_error_monitor.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_error_monitor_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// The histogram thresholds and hist_bin() are used only when ERR_HIST_EN is defined.
package approx_mon_pkg;

   localparam int DEF_DW  = 9;
   localparam int HIST_T1 = 1;
   localparam int HIST_T2 = 4;
   localparam int HIST_T3 = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_DRAIN  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   // Maps an error distance onto one of the four histogram bins.
   function automatic logic [1:0] hist_bin(input int unsigned ed);
      if (ed < HIST_T1)      return 2'd0;
      else if (ed < HIST_T2) return 2'd1;
      else if (ed < HIST_T3) return 2'd2;
      else                   return 2'd3;
   endfunction

endpackage

// File: rtl/approx_error_monitor_if.sv
// Sample, control and report bundle of the error monitor.
// When ERR_HIST_EN is defined, the bundle also carries the packed histogram.
interface approx_error_monitor_if #(
   parameter int DW     = 9,
   parameter int WINDOW = 256
);
   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam int SUM_W = DW + CNT_W;

   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    approx_sum;
   logic [DW-1:0]    exact_sum;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] err_cnt;
   logic [SUM_W-1:0] ed_sum;
   logic [DW-1:0]    ed_max;
   logic             busy;
`ifdef ERR_HIST_EN
   logic [4*CNT_W-1:0] hist;

   modport master (
      output start, in_valid, approx_sum, exact_sum, res_ready,
      input  in_ready, res_valid, err_cnt, ed_sum, ed_max, busy, hist
   );
   modport slave (
      input  start, in_valid, approx_sum, exact_sum, res_ready,
      output in_ready, res_valid, err_cnt, ed_sum, ed_max, busy, hist
   );
`else
   modport master (
      output start, in_valid, approx_sum, exact_sum, res_ready,
      input  in_ready, res_valid, err_cnt, ed_sum, ed_max, busy
   );
   modport slave (
      input  start, in_valid, approx_sum, exact_sum, res_ready,
      output in_ready, res_valid, err_cnt, ed_sum, ed_max, busy
   );
`endif
endinterface

// File: rtl/approx_error_monitor_err_dist_calc.sv
// Single registered stage that turns an (exact, approx) pair into |exact - approx|.
module err_dist_calc #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_p0_i,
   input  logic [DW-1:0] approx_p0_i,
   input  logic [DW-1:0] exact_p0_i,
   output logic [DW-1:0] ed_p1_o,
   output logic          vld_p1_o
);

   logic signed [DW:0] diff_p0;
   logic [DW-1:0]      ed_p1_q;
   logic               vld_p1_q;

   // The magnitude of a (DW+1)-bit difference of two unsigned DW-bit values always fits in DW bits.
   function automatic logic [DW-1:0] abs_dist(input logic signed [DW:0] d);
      logic signed [DW:0] m;
      m = d[DW] ? -d : d;
      return m[DW-1:0];
   endfunction

   assign diff_p0 = $signed({1'b0, exact_p0_i}) - $signed({1'b0, approx_p0_i});

   // ---- stage p0 -> p1 ----
   always_ff @(posedge clk) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= vld_p0_i;
   end

   always_ff @(posedge clk) begin
      if (vld_p0_i) ed_p1_q <= abs_dist(diff_p0);
   end

   assign ed_p1_o  = ed_p1_q;
   assign vld_p1_o = vld_p1_q;

endmodule

// File: rtl/approx_error_monitor.sv
// Window-based error statistics (count, summed and maximum error distance) for the approximate adder.
// Defining ERR_HIST_EN adds a four-bin error-distance histogram to the report.
module approx_error_monitor
   import approx_mon_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int WINDOW = 256
) (
   input logic                   clk,
   input logic                   rst,
   approx_error_monitor_if.slave bus
);

   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam int SUM_W = DW + CNT_W;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             drain_q;
   logic             in_ready_q;
   logic             res_valid_q;
   logic             accept_p0;

   logic [DW-1:0]    ed_p1;
   logic             vld_p1;

   logic [CNT_W-1:0] err_cnt_q;
   logic [SUM_W-1:0] ed_sum_q;
   logic [DW-1:0]    ed_max_q;
   logic             clear_acc;

   assign accept_p0 = bus.in_valid && in_ready_q;
   assign clear_acc = (state_q == S_IDLE) && bus.start;

   // DRAIN lasts two cycles so the last accepted sample has reached the accumulators.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         drain_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q    <= S_ACCUM;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (accept_p0) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WINDOW - 1)) begin
                     state_q    <= S_DRAIN;
                     in_ready_q <= 1'b0;
                     drain_q    <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q) begin
                  state_q     <= S_REPORT;
                  res_valid_q <= 1'b1;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            S_REPORT: begin
               if (bus.res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   err_dist_calc #(.DW(DW)) u_err_dist_calc (
      .clk         (clk),
      .rst         (rst),
      .vld_p0_i    (accept_p0),
      .approx_p0_i (bus.approx_sum),
      .exact_p0_i  (bus.exact_sum),
      .ed_p1_o     (ed_p1),
      .vld_p1_o    (vld_p1)
   );

   // ---- stage p1 -> p2: accumulate ----
   always_ff @(posedge clk) begin
      if (rst || clear_acc) begin
         err_cnt_q <= '0;
         ed_sum_q  <= '0;
         ed_max_q  <= '0;
      end else if (vld_p1) begin
         err_cnt_q <= err_cnt_q + CNT_W'(ed_p1 != '0);
         ed_sum_q  <= ed_sum_q + SUM_W'(ed_p1);
         if (ed_p1 > ed_max_q) ed_max_q <= ed_p1;
      end
   end

`ifdef ERR_HIST_EN
   logic [CNT_W-1:0] hist_q [4];
   logic [1:0]       bin_p1;

   assign bin_p1 = hist_bin(32'(ed_p1));

   always_ff @(posedge clk) begin
      if (rst || clear_acc) begin
         for (int b = 0; b < 4; b++) hist_q[b] <= '0;
      end else if (vld_p1) begin
         hist_q[bin_p1] <= hist_q[bin_p1] + 1'b1;
      end
   end

   always_comb begin
      bus.hist = '0;
      if (res_valid_q) begin
         for (int b = 0; b < 4; b++) bus.hist[b*CNT_W +: CNT_W] = hist_q[b];
      end
   end
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.err_cnt   = res_valid_q ? err_cnt_q : '0;
   assign bus.ed_sum    = res_valid_q ? ed_sum_q  : '0;
   assign bus.ed_max    = res_valid_q ? ed_max_q  : '0;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomised self-checking bench for approx_error_monitor (WINDOW=4); checks hist when ERR_HIST_EN is defined.
module tb_approx_error_monitor;

   localparam int DW    = 9;
   localparam int WIN   = 4;
   localparam int CNT_W = $clog2(WIN + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   approx_error_monitor_if #(.DW(DW), .WINDOW(WIN)) bus ();
   approx_error_monitor #(.DW(DW), .WINDOW(WIN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 reporting.
   int m_phase = 0;
   int m_drain = 0;
   int m_ed[$];
   bit m_live  = 1'b0;

   function automatic int edist(input int e, input int a);
      return (e > a) ? e - a : a - e;
   endfunction

   function automatic int exp_err();
      int n = 0;
      if (m_phase == 3) foreach (m_ed[i]) if (m_ed[i] != 0) n++;
      return n;
   endfunction

   function automatic int exp_sum();
      int s = 0;
      if (m_phase == 3) foreach (m_ed[i]) s += m_ed[i];
      return s;
   endfunction

   function automatic int exp_max();
      int m = 0;
      if (m_phase == 3) foreach (m_ed[i]) if (m_ed[i] > m) m = m_ed[i];
      return m;
   endfunction

   function automatic int exp_bin(input int b);
      int n = 0;
      if (m_phase == 3) begin
         foreach (m_ed[i]) begin
            if (b == 0 && m_ed[i] == 0) n++;
            if (b == 1 && m_ed[i] >= 1 && m_ed[i] <= 3) n++;
            if (b == 2 && m_ed[i] >= 4 && m_ed[i] <= 15) n++;
            if (b == 3 && m_ed[i] >= 16) n++;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_ed.delete();
         m_live  = 1'b1;
      end else if (m_live) begin
         case (m_phase)
            0: if (bus.start) begin m_ed.delete(); m_phase = 1; end
            1: if (bus.in_valid) begin
                  m_ed.push_back(edist(int'(bus.exact_sum), int'(bus.approx_sum)));
                  if (m_ed.size() == WIN) begin m_phase = 2; m_drain = 2; end
               end
            2: begin m_drain--; if (m_drain == 0) m_phase = 3; end
            default: if (bus.res_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready",  longint'(bus.in_ready),  longint'(m_phase == 1 && m_ed.size() < WIN));
         chk("res_valid", longint'(bus.res_valid), longint'(m_phase == 3));
         chk("busy",      longint'(bus.busy),      longint'(m_phase != 0));
         chk("err_cnt",   longint'(bus.err_cnt),   longint'(exp_err()));
         chk("ed_sum",    longint'(bus.ed_sum),    longint'(exp_sum()));
         chk("ed_max",    longint'(bus.ed_max),    longint'(exp_max()));
`ifdef ERR_HIST_EN
         for (int b = 0; b < 4; b++)
            chk("hist_bin", longint'(bus.hist[b*CNT_W +: CNT_W]), longint'(exp_bin(b)));
`endif
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic send(input int e, input int a);
      bit ok = 1'b0;
      @(negedge clk);
      bus.exact_sum  = DW'(e);
      bus.approx_sum = DW'(a);
      bus.in_valid   = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (bus.in_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_report();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (bus.res_valid) return;
      end
      chk("report_timeout", 0, 1);
   endtask

   task automatic ack(input int hold);
      repeat (hold) @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic send_t3();
      send(32'h15A, 32'h156);
      send(32'h1A0, 32'h1A0);
      send(32'h000, 32'h1FF);
      send(32'h0C3, 32'h0C1);
   endtask

   task automatic check_t3(input string tag);
      chk({tag, "_err_cnt"}, longint'(bus.err_cnt), 3);
      chk({tag, "_ed_sum"},  longint'(bus.ed_sum), 517);
      chk({tag, "_ed_max"},  longint'(bus.ed_max), 511);
`ifdef ERR_HIST_EN
      for (int b = 0; b < 4; b++) chk({tag, "_hist"}, longint'(bus.hist[b*CNT_W +: CNT_W]), 1);
`endif
   endtask

   int pat [6] = '{1, 0, 1, 1, 0, 1};
   int acc;
   int v;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
      bus.approx_sum = '0; bus.exact_sum = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a window
      pulse_start();
      send(10, 3);
      send(7, 7);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", longint'(bus.in_ready), 0);
      chk("rst_res_valid", longint'(bus.res_valid), 0);
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_err_cnt", longint'(bus.err_cnt), 0);
      chk("rst_ed_sum", longint'(bus.ed_sum), 0);
      chk("rst_ed_max", longint'(bus.ed_max), 0);

      // Exact == approx for a whole window
      pulse_start();
      for (int i = 0; i < WIN; i++) begin v = int'($urandom_range(0, 511)); send(v, v); end
      wait_report();
      chk("zero_err_cnt", longint'(bus.err_cnt), 0);
      chk("zero_ed_sum", longint'(bus.ed_sum), 0);
      chk("zero_ed_max", longint'(bus.ed_max), 0);
      ack(0);

      // Fixed pairs with known statistics, including the 511 extreme
      pulse_start();
      send_t3();
      wait_report();
      check_t3("t3");
      chk("model_sum", longint'(exp_sum()), 517);
      chk("model_err", longint'(exp_err()), 3);
      ack(2);

      // Valid toggling with a long back-pressured report
      pulse_start();
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         bus.in_valid = pat[k][0];
         bus.exact_sum = DW'($urandom_range(0, 511));
         bus.approx_sum = DW'($urandom_range(0, 511));
         if (pat[k] != 0 && bus.in_ready) acc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("hs_accepted", longint'(acc), 4);
      chk("hs_in_ready_after", longint'(bus.in_ready), 0);
      wait_report();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("hs_hold_valid", longint'(bus.res_valid), 1);
      end
      ack(0);
      chk("hs_released", longint'(bus.res_valid), 0);
      chk("hs_idle", longint'(bus.busy), 0);

      // Start ignored in ACCUM and REPORT; honoured again in IDLE
      pulse_start();
      send(32'h15A, 32'h156);
      send(32'h1A0, 32'h1A0);
      pulse_start();
      send(32'h000, 32'h1FF);
      send(32'h0C3, 32'h0C1);
      wait_report();
      check_t3("s_accum");
      pulse_start();
      check_t3("s_report");
      @(negedge clk);
      bus.start = 1'b1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.res_ready = 1'b0;
      chk("s_ack_idle", longint'(bus.busy), 0);
      pulse_start();
      for (int i = 0; i < WIN; i++) send(100, 100);
      wait_report();
      chk("s_fresh_err_cnt", longint'(bus.err_cnt), 0);
      chk("s_fresh_ed_sum", longint'(bus.ed_sum), 0);
      ack(1);

      // Randomised windows
      for (int w = 0; w < 40; w++) begin
         pulse_start();
         for (int i = 0; i < WIN; i++) begin
            int e, a, mode;
            mode = int'($urandom_range(0, 3));
            e = int'($urandom_range(0, 511));
            case (mode)
               0: a = e;
               1: a = int'($urandom_range(0, 511));
               2: begin e = ($urandom_range(0, 1) != 0) ? 511 : 0; a = 511 - e; end
               default: a = (e + int'($urandom_range(1, 20))) % 512;
            endcase
            if ($urandom_range(0, 3) == 0) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               bus.start = ($urandom_range(0, 1) != 0);
               @(negedge clk);
               bus.start = 1'b0;
            end
            send(e, a);
         end
         wait_report();
         if ($urandom_range(0, 2) == 0) pulse_start();
         ack(int'($urandom_range(0, 5)));
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
